// File: rtl/vram_arbiter.sv
// VRAM port arbiter: display reads take priority over CPU writes,
// which queue in a small in-order FIFO drained on idle cycles.
module vram_arbiter #(
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    disp_req,
  input  logic [ADDR_W-1:0]       disp_addr,
  output logic [DATA_W-1:0]       disp_data,
  output logic                    disp_valid,
  input  logic                    cpu_wr_valid,
  output logic                    cpu_wr_ready,
  input  logic [ADDR_W-1:0]       cpu_wr_addr,
  input  logic [DATA_W-1:0]       cpu_wr_data,
  output logic [ADDR_W-1:0]       vram_address,
  output logic                    vram_w_enable,
  output logic [DATA_W-1:0]       vram_w_data,
  input  logic [DATA_W-1:0]       vram_r_data,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    starve
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [SW-1:0]     starve_cnt;
  logic              not_empty;
  logic              push;
  logic              pop;

  assign not_empty    = count != '0;
  assign cpu_wr_ready = count < CW'(DEPTH);
  assign push         = cpu_wr_valid && cpu_wr_ready;
  assign pop          = state_nx == WRITE;
  assign fifo_count   = count;
  assign disp_data    = vram_r_data;

  always_comb begin
    state_nx = IDLE;
    priority case (1'b1)
      disp_req:  state_nx = READ;
      not_empty: state_nx = WRITE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= cpu_wr_addr;
      mem_data[wr_ptr] <= cpu_wr_data;
    end
  end

  // disp_valid is the second stage behind the READ grant in state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      vram_address  <= '0;
      vram_w_enable <= 1'b0;
      vram_w_data   <= '0;
      disp_valid    <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      starve_cnt    <= '0;
      starve        <= 1'b0;
    end else begin
      state         <= state_nx;
      disp_valid    <= state == READ;
      vram_w_enable <= 1'b0;
      unique case (state_nx)
        READ: vram_address <= disp_addr;
        WRITE: begin
          vram_address  <= mem_addr[rd_ptr];
          vram_w_data   <= mem_data[rd_ptr];
          vram_w_enable <= 1'b1;
        end
        default: ;
      endcase
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (!not_empty || pop)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + SW'(1);
      if (starve_cnt == SW'(STARVE_LIMIT))
        starve <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: vector table, directed corner
// sequences and random traffic against a queue-based model.
module tb_vram_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        disp_req;
  logic [19:0] disp_addr;
  logic [15:0] disp_data;
  logic        disp_valid;
  logic        cpu_wr_valid;
  logic        cpu_wr_ready;
  logic [19:0] cpu_wr_addr;
  logic [15:0] cpu_wr_data;
  logic [19:0] vram_address;
  logic        vram_w_enable;
  logic [15:0] vram_w_data;
  logic [15:0] vram_r_data;
  logic [2:0]  fifo_count;
  logic        starve;

  int total = 0;
  int bad   = 0;

  vram_arbiter #(
    .ADDR_W(20),
    .DATA_W(16),
    .DEPTH(DEPTH),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .disp_req(disp_req),
    .disp_addr(disp_addr),
    .disp_data(disp_data),
    .disp_valid(disp_valid),
    .cpu_wr_valid(cpu_wr_valid),
    .cpu_wr_ready(cpu_wr_ready),
    .cpu_wr_addr(cpu_wr_addr),
    .cpu_wr_data(cpu_wr_data),
    .vram_address(vram_address),
    .vram_w_enable(vram_w_enable),
    .vram_w_data(vram_w_data),
    .vram_r_data(vram_r_data),
    .fifo_count(fifo_count),
    .starve(starve)
  );

  always #5 clk = ~clk;

  // synchronous VRAM stand-in: data = address + 0x100
  always @(posedge clk)
    vram_r_data <= vram_address[15:0] + 16'h0100;

  typedef struct packed {
    logic [19:0] a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic        dr;
    logic [19:0] da;
    logic        wv;
    logic [19:0] wa;
    logic [15:0] wd;
    logic        e_dv;
    logic [15:0] e_dd;
    logic        e_we;
    logic [19:0] e_va;
    logic [15:0] e_vd;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tbl[17];

  wr_t         q[$];
  logic        m_we;
  logic [19:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rd1;
  logic [15:0] m_rd2;
  logic        h1;
  logic        h2;
  logic        m_starve;
  int          deny;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_we     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_rd1    = '0;
    m_rd2    = '0;
    h1       = 1'b0;
    h2       = 1'b0;
    m_starve = 1'b0;
    deny     = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_we", 32'(vram_w_enable), 32'(0));
    chk("rst_va", 32'(vram_address), 32'(0));
    chk("rst_vd", 32'(vram_w_data), 32'(0));
    chk("rst_dv", 32'(disp_valid), 32'(0));
    chk("rst_cnt", 32'(fifo_count), 32'(0));
    chk("rst_rdy", 32'(cpu_wr_ready), 32'(1));
    chk("rst_starve", 32'(starve), 32'(0));
    disp_req     = 1'b0;
    cpu_wr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // check this cycle against the model, drive, advance the model
  task automatic step(input logic dr, input logic [19:0] da,
                      input logic wv, input logic [19:0] wa,
                      input logic [15:0] wd);
    wr_t  e;
    logic rdy;
    rdy = q.size() < DEPTH;
    chk("count", 32'(fifo_count), 32'(q.size()));
    chk("ready", 32'(cpu_wr_ready), 32'(rdy));
    chk("we", 32'(vram_w_enable), 32'(m_we));
    chk("vaddr", 32'(vram_address), 32'(m_addr));
    chk("vdata", 32'(vram_w_data), 32'(m_wdata));
    chk("dvalid", 32'(disp_valid), 32'(h2));
    if (h2) chk("ddata", 32'(disp_data), 32'(m_rd2));
    chk("starve", 32'(starve), 32'(m_starve));
    disp_req     = dr;
    disp_addr    = da;
    cpu_wr_valid = wv;
    cpu_wr_addr  = wa;
    cpu_wr_data  = wd;
    if (deny == LIMIT) m_starve = 1'b1;
    h2    = h1;
    m_rd2 = m_rd1;
    h1    = dr;
    m_rd1 = da[15:0] + 16'h0100;
    if (dr) begin
      m_we   = 1'b0;
      m_addr = da;
      if (q.size() == 0) deny = 0;
      else if (deny < LIMIT) deny++;
    end else if (q.size() != 0) begin
      e       = q.pop_front();
      m_we    = 1'b1;
      m_addr  = e.a;
      m_wdata = e.d;
      deny    = 0;
    end else begin
      m_we = 1'b0;
      deny = 0;
    end
    if (wv && rdy) q.push_back('{a: wa, d: wd});
    @(negedge clk);
  endtask

  initial begin
    disp_req     = 1'b0;
    disp_addr    = '0;
    cpu_wr_valid = 1'b0;
    cpu_wr_addr  = '0;
    cpu_wr_data  = '0;
    model_reset();

    // dr da wv wa wd | dv dd we va vd cnt
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 'h11, 0, 0, 0, 0, 0, 0, 'h10, 0, 0};
    tbl[5]  = '{1, 'h12, 0, 0, 0, 1, 'h110, 0, 'h11, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 1, 'h111, 0, 'h12, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 1, 'h112, 0, 'h12, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 'h12, 0, 0};
    tbl[9]  = '{0, 0, 1, 'h20, 'hA1B2,
                0, 0, 0, 'h12, 0, 0};
    tbl[10] = '{0, 0, 1, 'h21, 'hA1B3,
                0, 0, 0, 'h12, 0, 1};
    tbl[11] = '{0, 0, 1, 'h22, 'hA1B4,
                0, 0, 1, 'h20, 'hA1B2, 1};
    tbl[12] = '{0, 0, 1, 'h23, 'hA1B5,
                0, 0, 1, 'h21, 'hA1B3, 1};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 1, 'h22, 'hA1B4, 1};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 1, 'h23, 'hA1B5, 0};
    tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 'h23, 'hA1B5, 0};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 'h23, 'hA1B5, 0};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 17; i++) begin
      chk($sformatf("row%0d_dv", i),
          32'(disp_valid), 32'(tbl[i].e_dv));
      if (tbl[i].e_dv)
        chk($sformatf("row%0d_dd", i),
            32'(disp_data), 32'(tbl[i].e_dd));
      chk($sformatf("row%0d_we", i),
          32'(vram_w_enable), 32'(tbl[i].e_we));
      chk($sformatf("row%0d_va", i),
          32'(vram_address), 32'(tbl[i].e_va));
      chk($sformatf("row%0d_vd", i),
          32'(vram_w_data), 32'(tbl[i].e_vd));
      chk($sformatf("row%0d_cnt", i),
          32'(fifo_count), 32'(tbl[i].e_cnt));
      chk($sformatf("row%0d_rdy", i),
          32'(cpu_wr_ready), 32'(1));
      disp_req     = tbl[i].dr;
      disp_addr    = tbl[i].da;
      cpu_wr_valid = tbl[i].wv;
      cpu_wr_addr  = tbl[i].wa;
      cpu_wr_data  = tbl[i].wd;
      @(negedge clk);
    end

    // display hogs the port: FIFO fills, starve latches
    do_reset();
    for (int i = 0; i < 5; i++)
      step(1, 'h50, 1, 20'('h100 + i), 16'('hC000 + i));
    repeat (70) step(1, 'h50, 0, 0, 0);
    chk("hog_cnt", 32'(fifo_count), 32'(4));
    chk("hog_rdy", 32'(cpu_wr_ready), 32'(0));
    chk("hog_starve", 32'(starve), 32'(1));
    repeat (8) step(0, 0, 0, 0, 0);
    chk("drain_starve", 32'(starve), 32'(1));
    chk("drain_cnt", 32'(fifo_count), 32'(0));

    // full FIFO with writer held valid while draining
    do_reset();
    for (int i = 0; i < 4; i++)
      step(1, 'h60, 1, 20'('h200 + i), 16'('hD000 + i));
    for (int i = 0; i < 10; i++)
      step(0, 0, 1, 20'('h300 + i), 16'('hE000 + i));
    repeat (6) step(0, 0, 0, 0, 0);

    // reset mid-drain with reads in flight
    do_reset();
    for (int i = 0; i < 4; i++)
      step(1, 'h70, 1, 20'('h400 + i), 16'('hF000 + i));
    step(0, 0, 0, 0, 0);
    chk("mid_cnt", 32'(fifo_count), 32'(3));
    disp_req  = 1'b1;
    disp_addr = 'h71;
    do_reset();
    repeat (8) step(0, 0, 0, 0, 0);

    // random traffic in blocks of varying read pressure
    do_reset();
    for (int b = 0; b < 15; b++) begin
      int pr;
      int pw;
      pr = $urandom_range(0, 9);
      pw = $urandom_range(2, 9);
      for (int i = 0; i < 200; i++)
        step($urandom_range(0, 9) < pr, 20'($urandom),
             $urandom_range(0, 9) < pw, 20'($urandom),
             16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
